// File: rtl/eth_phy_10g_rx_link_ctrl_pkg.sv
// Shared types and helpers for the 10G RX link controller.
// State encodings are visible to the bench through this package.
package eth_phy_10g_rx_link_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_STABLE    = 3'd3,
    ST_UP        = 3'd4,
    ST_FAULT     = 3'd5
  } link_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_link_ctrl_if.sv
// Status/control bundle between the link controller and its user.
// slave = controller side, master = driver of cfg and monitor inputs.
interface eth_phy_10g_rx_link_ctrl_if #(
  parameter int MAX_RETRIES = 3,
  parameter int CNT_WIDTH   = 16
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic                 cfg_enable;
  logic                 rx_block_lock;
  logic                 rx_high_ber;
  logic                 serdes_rx_reset_req;
  logic                 link_up;
  logic                 link_fault;
  logic [2:0]           link_state;
  logic [RW-1:0]        retry_count;
  logic [CNT_WIDTH-1:0] link_down_count;

  modport master (
    output cfg_enable, rx_block_lock, rx_high_ber,
    input  serdes_rx_reset_req, link_up, link_fault,
    input  link_state, retry_count, link_down_count
  );

  modport slave (
    input  cfg_enable, rx_block_lock, rx_high_ber,
    output serdes_rx_reset_req, link_up, link_fault,
    output link_state, retry_count, link_down_count
  );
endinterface

// File: rtl/eth_phy_10g_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module eth_phy_10g_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && (count_q != '1))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// RX link bring-up controller: SERDES reset sequencing, lock
// qualification, link_up declaration and retry/fault supervision.
module eth_phy_10g_rx_link_ctrl
  import eth_phy_10g_rx_link_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 4,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 128,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic rx_clk,
  input  logic rx_rst,
  eth_phy_10g_rx_link_ctrl_if.slave bus
);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int TW =
    $clog2(max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] LT_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R    = RW'(MAX_RETRIES);

  link_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          req_q, req_d;
  logic          up_q, up_d;
  logic          fault_q, fault_d;
  logic          clean;
  logic          down_inc;

  assign clean = bus.rx_block_lock & ~bus.rx_high_ber;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = (timer_q == '1) ? timer_q : timer_q + TW'(1);
    if (!bus.cfg_enable) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_RESET;
        ST_RESET: begin
          if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          // lock beats a coincident timeout
          if (bus.rx_block_lock) begin
            state_d = ST_STABLE;
          end else if (timer_q == LT_LAST) begin
            retry_d = retry_q + RW'(1);
            state_d = (retry_d == MAX_R) ? ST_FAULT : ST_RESET;
          end
        end
        ST_STABLE: begin
          if (!clean) begin
            state_d = ST_WAIT_LOCK;
          end else if (timer_q == STB_LAST) begin
            state_d = ST_UP;
            retry_d = '0;
          end
        end
        ST_UP: begin
          if (!clean) state_d = ST_WAIT_LOCK;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (!bus.cfg_enable || (state_d != state_q)) timer_d = '0;
    req_d   = (state_d == ST_RESET);
    up_d    = (state_d == ST_UP);
    fault_d = (state_d == ST_FAULT);
  end

  assign down_inc = (state_q == ST_UP) && (state_d != ST_UP);

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      up_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      req_q   <= req_d;
      up_q    <= up_d;
      fault_q <= fault_d;
    end
  end

  eth_phy_10g_sat_counter #(.WIDTH(CNT_WIDTH)) u_down_cnt (
    .clk   (rx_clk),
    .rst   (rx_rst),
    .inc   (down_inc),
    .clr   (1'b0),
    .count (bus.link_down_count)
  );

  assign bus.serdes_rx_reset_req = req_q;
  assign bus.link_up             = up_q;
  assign bus.link_fault          = fault_q;
  assign bus.link_state          = state_q;
  assign bus.retry_count         = retry_q;
endmodule
